// File: rtl/atmega_adc_pkg.sv
// Shared register bit layout, conversion FSM encoding and default conversion lengths
// for the ATmega-style ADC controller.
package atmega_adc_pkg;

    localparam int unsigned ADEN_BIT  = 7;
    localparam int unsigned ADSC_BIT  = 6;
    localparam int unsigned ADATE_BIT = 5;
    localparam int unsigned ADIF_BIT  = 4;
    localparam int unsigned ADIE_BIT  = 3;
    localparam int unsigned ADLAR_BIT = 5;

    localparam int unsigned DEF_FIRST_CONV_TICKS = 25;
    localparam int unsigned DEF_CONV_TICKS       = 13;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFirst = 2'd1,
        StConv  = 2'd2
    } adc_state_e;

    // ADPS=0 behaves like ADPS=1 (divide by 2); ADPS=7 yields the full 7-bit mask.
    function automatic logic [6:0] tick_mask(input logic [2:0] adps);
        logic [2:0] sh;
        sh = (adps == 3'd0) ? 3'd1 : adps;
        return (7'd1 << sh) - 7'd1;
    endfunction

endpackage

// File: rtl/atmega_adc_prescaler.sv
// Free-running ADC clock prescaler: counts while enabled, held at zero otherwise,
// and flags one tick every 2^max(adps,1) clocks.
module atmega_adc_prescaler
    import atmega_adc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [2:0] adps_i,
    output logic       tick_o
);

    logic [6:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 7'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign tick_o = en_i && ((cnt_q & tick_mask(adps_i)) == tick_mask(adps_i));

endmodule

// File: rtl/atmega_adc_ctrl.sv
// ATmega-style ADC controller: I/O registers, conversion FSM, auto-trigger,
// result alignment with read lock, and interrupt flag handling.
module atmega_adc_ctrl
    import atmega_adc_pkg::*;
#(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned ADCL_ADDR         = 'h78,
    parameter int unsigned ADCH_ADDR         = 'h79,
    parameter int unsigned ADCSRA_ADDR       = 'h7A,
    parameter int unsigned ADCSRB_ADDR       = 'h7B,
    parameter int unsigned ADMUX_ADDR        = 'h7C,
    parameter int unsigned FIRST_CONV_TICKS  = DEF_FIRST_CONV_TICKS,
    parameter int unsigned CONV_TICKS        = DEF_CONV_TICKS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    input  logic [9:0]                   sample_i,
    output logic                         sample_stb_o,
    input  logic                         trig_i,
    output logic                         int_o,
    input  logic                         int_ack_i
);

    localparam logic [BUS_ADDR_DATA_LEN-1:0] AddrAdcl   = BUS_ADDR_DATA_LEN'(ADCL_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] AddrAdch   = BUS_ADDR_DATA_LEN'(ADCH_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] AddrAdcsra = BUS_ADDR_DATA_LEN'(ADCSRA_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] AddrAdcsrb = BUS_ADDR_DATA_LEN'(ADCSRB_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] AddrAdmux  = BUS_ADDR_DATA_LEN'(ADMUX_ADDR);
    localparam logic [7:0] FirstLast = 8'(FIRST_CONV_TICKS - 1);
    localparam logic [7:0] ConvLast  = 8'(CONV_TICKS - 1);

    adc_state_e state_q, state_d;
    logic       aden_q, aden_d, adate_q, adate_d, adif_q, adif_d, adie_q, adie_d;
    logic [2:0] adps_q, adps_d, adts_q, adts_d;
    logic [7:0] admux_q, admux_d, adcl_q, adcl_d, adch_q, adch_d;
    logic       lock_q, lock_d, first_q, first_d, done_q, trig_q, trig_prev_q;
    logic [7:0] tick_cnt_q, tick_cnt_d, last_tick;
    logic       sel_adcl, sel_adch, sel_adcsra, sel_adcsrb, sel_admux, wr_adcsra;
    logic       trig_edge, auto_start, start, presc_en, tick, busy, done;

    assign sel_adcl   = (addr_i == AddrAdcl);
    assign sel_adch   = (addr_i == AddrAdch);
    assign sel_adcsra = (addr_i == AddrAdcsra);
    assign sel_adcsrb = (addr_i == AddrAdcsrb);
    assign sel_admux  = (addr_i == AddrAdmux);
    assign wr_adcsra  = wr_i && sel_adcsra;

    assign aden_d     = wr_adcsra ? bus_i[ADEN_BIT] : aden_q;
    assign trig_edge  = trig_q && !trig_prev_q;
    // Free-running mode restarts off the previous completion; other sources use the trigger edge.
    assign auto_start = adate_q && ((adts_q == 3'd0) ? done_q : trig_edge);
    assign start      = (state_q == StIdle) && aden_d &&
                        ((wr_adcsra && bus_i[ADSC_BIT]) || auto_start);
    // Prescaler restarts with each conversion so tick phase is fixed relative to the start.
    assign presc_en   = aden_q && !start;

    atmega_adc_prescaler u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (presc_en),
        .adps_i (adps_q),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:         if (start) state_d = first_q ? StFirst : StConv;
            StFirst, StConv: if (!aden_q || done) state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        last_tick = ConvLast;
        unique case (state_q)
            StFirst: begin
                busy      = 1'b1;
                last_tick = FirstLast;
            end
            StConv:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
        done         = busy && tick && (tick_cnt_q == last_tick);
        sample_stb_o = done;
    end

    always_comb begin
        adate_d    = adate_q;
        adie_d     = adie_q;
        adps_d     = adps_q;
        adts_d     = adts_q;
        admux_d    = admux_q;
        adif_d     = adif_q;
        adcl_d     = adcl_q;
        adch_d     = adch_q;
        lock_d     = lock_q;
        first_d    = first_q;
        tick_cnt_d = tick_cnt_q;
        if (wr_adcsra) begin
            adate_d = bus_i[ADATE_BIT];
            adie_d  = bus_i[ADIE_BIT];
            adps_d  = bus_i[2:0];
        end
        if (wr_i && sel_adcsrb) adts_d = bus_i[2:0];
        if (wr_i && sel_admux) admux_d = bus_i;
        if (rd_i && sel_adcl) begin
            lock_d = 1'b1;
        end else if (rd_i && sel_adch) begin
            lock_d = 1'b0;
        end
        if ((wr_adcsra && bus_i[ADIF_BIT]) || int_ack_i) adif_d = 1'b0;
        if (done) adif_d = 1'b1;
        if (done && !lock_q) begin
            if (admux_q[ADLAR_BIT]) begin
                adch_d = sample_i[9:2];
                adcl_d = {sample_i[1:0], 6'b0};
            end else begin
                adch_d = {6'b0, sample_i[9:8]};
                adcl_d = sample_i[7:0];
            end
        end
        if (!aden_d) begin
            first_d = 1'b1;
        end else if (start) begin
            first_d = 1'b0;
        end
        if (start) begin
            tick_cnt_d = '0;
        end else if (busy && tick) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aden_q      <= 1'b0;
            adate_q     <= 1'b0;
            adif_q      <= 1'b0;
            adie_q      <= 1'b0;
            adps_q      <= '0;
            adts_q      <= '0;
            admux_q     <= '0;
            adcl_q      <= '0;
            adch_q      <= '0;
            lock_q      <= 1'b0;
            first_q     <= 1'b1;
            tick_cnt_q  <= '0;
            done_q      <= 1'b0;
            trig_q      <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            aden_q      <= aden_d;
            adate_q     <= adate_d;
            adif_q      <= adif_d;
            adie_q      <= adie_d;
            adps_q      <= adps_d;
            adts_q      <= adts_d;
            admux_q     <= admux_d;
            adcl_q      <= adcl_d;
            adch_q      <= adch_d;
            lock_q      <= lock_d;
            first_q     <= first_d;
            tick_cnt_q  <= tick_cnt_d;
            done_q      <= done;
            trig_q      <= trig_i;
            trig_prev_q <= trig_q;
        end
    end

    assign int_o = adif_q && adie_q;

    always_comb begin
        bus_o = '0;
        if (rd_i) begin
            if (sel_adcl) begin
                bus_o = adcl_q;
            end else if (sel_adch) begin
                bus_o = adch_q;
            end else if (sel_adcsra) begin
                bus_o = {aden_q, busy, adate_q, adif_q, adie_q, adps_q};
            end else if (sel_adcsrb) begin
                bus_o = {5'b0, adts_q};
            end else if (sel_admux) begin
                bus_o = admux_q;
            end
        end
    end

endmodule

// File: tb/tb_atmega_adc_ctrl.sv
// Scoreboard bench for atmega_adc_ctrl: expected strobe cycles are queued at stimulus time
// and popped by a strobe monitor; register contents are checked against an arithmetic model.
module tb_atmega_adc_ctrl;

    localparam logic [7:0] A_ADCL = 8'h78;
    localparam logic [7:0] A_ADCH = 8'h79;
    localparam logic [7:0] A_SRA  = 8'h7A;
    localparam logic [7:0] A_SRB  = 8'h7B;
    localparam logic [7:0] A_MUX  = 8'h7C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] bus_in = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] bus_out;
    logic [9:0] sample = 10'h000;
    logic       stb;
    logic       trig = 1'b0;
    logic       irq;
    logic       ack = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stb_count = 0;
    int exp_q[$];

    atmega_adc_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (addr),
        .wr_i         (wr),
        .rd_i         (rd),
        .bus_i        (bus_in),
        .bus_o        (bus_out),
        .sample_i     (sample),
        .sample_stb_o (stb),
        .trig_i       (trig),
        .int_o        (irq),
        .int_ack_i    (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, got, want);
        end
    endtask

    // Reference model: conversion length and result alignment from the register definitions.
    function automatic int conv_clocks(input int adps, input int ticks);
        return ((adps == 0) ? 2 : (1 << adps)) * ticks;
    endfunction

    function automatic logic [7:0] model_h(input logic [9:0] s, input bit adlar);
        return adlar ? 8'(int'(s) / 4) : 8'(int'(s) / 256);
    endfunction

    function automatic logic [7:0] model_l(input logic [9:0] s, input bit adlar);
        return adlar ? 8'((int'(s) % 4) * 64) : 8'(int'(s) % 256);
    endfunction

    always @(negedge clk) begin
        if (!rst && stb === 1'b1) begin
            stb_count++;
            if (exp_q.size() == 0) chk("unexpected strobe at cycle", cyc, -1);
            else chk("strobe cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, output int c);
        @(posedge clk); #1;
        addr = a; bus_in = d; wr = 1'b1; c = cyc;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] want);
        logic [7:0] d;
        @(posedge clk); #1;
        addr = a; rd = 1'b1;
        @(negedge clk);
        d = bus_out;
        @(posedge clk); #1;
        rd = 1'b0;
        chk(name, int'(d), int'(want));
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("strobe timeout, pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, n0, ps;
        bit al;
        logic [7:0] mux;
        logic [9:0] s1, s2, s3;

        // Reset state
        rd = 1'b1; addr = A_SRA;
        repeat (3) @(posedge clk);
        #2;
        chk("bus_o in reset", int'(bus_out), 0);
        chk("int_o in reset", int'(irq), 0);
        chk("strobe in reset", int'(stb), 0);
        rd = 1'b0;
        @(negedge clk) rst = 1'b0;
        rd_chk("reset ADCSRA", A_SRA, 8'h00);
        rd_chk("reset ADCSRB", A_SRB, 8'h00);
        rd_chk("reset ADMUX", A_MUX, 8'h00);
        rd_chk("reset ADCL", A_ADCL, 8'h00);
        rd_chk("reset ADCH", A_ADCH, 8'h00);

        // First conversion after enable
        sample = 10'h2A5;
        bus_wr(A_SRA, 8'hC0, wc);
        exp_q.push_back(wc + conv_clocks(0, 25));
        rd_chk("ADSC reads 1 while busy", A_SRA, 8'hC0);
        wait_empty(200);
        rd_chk("t1 ADCL", A_ADCL, model_l(sample, 0));
        rd_chk("t1 ADCH", A_ADCH, model_h(sample, 0));
        rd_chk("t1 ADCSRA", A_SRA, 8'h90);

        // Left-adjusted normal conversion
        bus_wr(A_MUX, 8'h20, wc);
        bus_wr(A_SRA, 8'hC0, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        wait_empty(200);
        rd_chk("t2 ADCL", A_ADCL, model_l(sample, 1));
        rd_chk("t2 ADCH", A_ADCH, model_h(sample, 1));

        // Randomised prescaler / alignment / sample
        for (int i = 0; i < 6; i++) begin
            ps = int'($urandom_range(0, 3));
            al = 1'($urandom_range(0, 1));
            mux = 8'($urandom);
            mux[5] = al;
            sample = 10'($urandom);
            bus_wr(A_MUX, mux, wc);
            bus_wr(A_SRA, 8'hD0 | 8'(ps), wc);
            exp_q.push_back(wc + conv_clocks(ps, 13));
            wait_empty(400);
            rd_chk("rand ADMUX", A_MUX, mux);
            rd_chk("rand ADCL", A_ADCL, model_l(sample, al));
            rd_chk("rand ADCH", A_ADCH, model_h(sample, al));
            rd_chk("rand ADCSRA", A_SRA, 8'h90 | 8'(ps));
        end

        // Interrupt: flag set, set-wins over acknowledge, standalone acknowledge
        bus_wr(A_SRA, 8'hD8, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        wait_empty(200);
        @(negedge clk);
        chk("int_o after completion", int'(irq), 1);
        bus_wr(A_SRA, 8'hD8, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        while (cyc < wc + conv_clocks(0, 13)) begin
            @(posedge clk); #1;
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        wait_empty(50);
        @(negedge clk);
        chk("int_o set wins over ack", int'(irq), 1);
        rd_chk("ADIF set wins over ack", A_SRA, 8'h98);
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        chk("int_o after ack", int'(irq), 0);

        // Read lock
        bus_wr(A_MUX, 8'h00, wc);
        s1 = 10'($urandom);
        s2 = ~s1;
        s3 = 10'($urandom);
        sample = s1;
        bus_wr(A_SRA, 8'hC0, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        wait_empty(200);
        rd_chk("lock ADCL first", A_ADCL, model_l(s1, 0));
        sample = s2;
        bus_wr(A_SRA, 8'hC0, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        wait_empty(200);
        rd_chk("lock ADCH keeps old", A_ADCH, model_h(s1, 0));
        sample = s3;
        bus_wr(A_SRA, 8'hC0, wc);
        exp_q.push_back(wc + conv_clocks(0, 13));
        wait_empty(200);
        rd_chk("unlocked ADCL", A_ADCL, model_l(s3, 0));
        rd_chk("unlocked ADCH", A_ADCH, model_h(s3, 0));

        // External trigger edge
        bus_wr(A_SRB, 8'h02, wc);
        bus_wr(A_SRA, 8'hB0, wc);
        @(posedge clk); #1;
        trig = 1'b1;
        wc = cyc;
        exp_q.push_back(wc + 1 + conv_clocks(0, 13));
        repeat (2) begin
            @(posedge clk); #1;
        end
        trig = 1'b0;
        wait_empty(200);
        rd_chk("trigger ADCSRA", A_SRA, 8'hB0);
        rd_chk("ADCSRB readback", A_SRB, 8'h02);

        // Free running, then disable mid-conversion
        bus_wr(A_SRA, 8'h00, wc);
        bus_wr(A_SRB, 8'h00, wc);
        bus_wr(A_SRA, 8'hF0, wc);
        exp_q.push_back(wc + conv_clocks(0, 25));
        exp_q.push_back(wc + conv_clocks(0, 25) + 1 + conv_clocks(0, 13));
        exp_q.push_back(wc + conv_clocks(0, 25) + 2 * (1 + conv_clocks(0, 13)));
        wait_empty(300);
        repeat (10) @(posedge clk);
        bus_wr(A_SRA, 8'h20, wc);
        n0 = stb_count;
        repeat (80) @(posedge clk);
        chk("strobes after ADEN=0", stb_count - n0, 0);
        rd_chk("ADIF kept after abort", A_SRA, 8'h30);

        // Asynchronous reset mid-conversion
        bus_wr(A_MUX, 8'h5A, wc);
        bus_wr(A_SRB, 8'h03, wc);
        bus_wr(A_SRA, 8'hC8, wc);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("int_o before reset", int'(irq), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        rd = 1'b1;
        addr = A_MUX;
        #1;
        chk("ADMUX in async reset", int'(bus_out), 0);
        chk("int_o in async reset", int'(irq), 0);
        chk("strobe in async reset", int'(stb), 0);
        addr = A_SRA;
        #1;
        chk("ADCSRA in async reset", int'(bus_out), 0);
        rd = 1'b0;
        @(negedge clk) rst = 1'b0;
        n0 = stb_count;
        rd_chk("post-reset ADCSRA", A_SRA, 8'h00);
        rd_chk("post-reset ADCSRB", A_SRB, 8'h00);
        rd_chk("post-reset ADMUX", A_MUX, 8'h00);
        rd_chk("post-reset ADCL", A_ADCL, 8'h00);
        rd_chk("post-reset ADCH", A_ADCH, 8'h00);
        repeat (80) @(posedge clk);
        chk("strobes after reset", stb_count - n0, 0);
        chk("pending strobes at end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atmega_adc_ctrl.md
ATMEGA_ADC_CTRL -- requirements
Module: atmega_adc_ctrl

Interface
REQ-001 Parameter BUS_ADDR_DATA_LEN, default 8, SHALL set the I/O address width.
REQ-002 Parameters ADCL_ADDR 'h78, ADCH_ADDR 'h79, ADCSRA_ADDR 'h7A, ADCSRB_ADDR 'h7B, ADMUX_ADDR 'h7C SHALL set the register addresses.
REQ-003 Parameter FIRST_CONV_TICKS, default 25, and CONV_TICKS, default 13, SHALL set the conversion lengths in prescaled ticks.
REQ-004 Port clk_i, input, 1 bit, SHALL be the single clock.
REQ-005 Port rst_i, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-006 Ports addr_i (input, BUS_ADDR_DATA_LEN), wr_i (input, 1), rd_i (input, 1) and bus_i (input, 8) SHALL form the I/O write/read bus.
REQ-007 Port bus_o, output, 8 bits, SHALL return read data.
REQ-008 Port sample_i, input, 10 bits, SHALL be the sample source, e.g. the LFSR/RNG value.
REQ-009 Port sample_stb_o, output, 1 bit, SHALL pulse on the capture cycle.
REQ-010 Port trig_i, input, 1 bit, SHALL be the external auto-trigger.
REQ-011 Port int_o, output, 1 bit, SHALL be the interrupt request.
REQ-012 Port int_ack_i, input, 1 bit, SHALL be the interrupt acknowledge.

Function
REQ-013 ADCSRA bits SHALL be: ADEN[7], ADSC[6], ADATE[5], ADIF[4], ADIE[3], ADPS[2:0]; ADCSRB[2:0] = ADTS; ADMUX = 8-bit R/W, bit5 = ADLAR.
REQ-014 Prescaler: 7-bit counter, running only while ADEN=1, cleared while ADEN=0; tick every 2^max(ADPS,1) clocks.
REQ-015 FSM states: IDLE, FIRST, CONV; FIRST counts FIRST_CONV_TICKS ticks, CONV counts CONV_TICKS ticks.
REQ-016 Start from IDLE: write ADSC=1 with ADEN=1 (same write allowed); first conversion after ADEN 0->1 -> FIRST, else -> CONV.
REQ-017 Auto-trigger: ADATE=1 and ADTS=0 -> restart CONV on the cycle after completion; ADATE=1 and ADTS!=0 -> start on a trig_i rising edge (registered) while in IDLE.
REQ-018 Completion (last tick): sample_stb_o=1 for one clock; sample_i latched the same cycle; ADIF set; ADSC cleared; FSM -> IDLE.
REQ-019 Result alignment, ADLAR=0: ADCH={6'b0,s[9:8]}, ADCL=s[7:0]; ADLAR=1: ADCH=s[9:2], ADCL={s[1:0],6'b0}; ADLAR is sampled at completion.
REQ-020 Read lock: reading ADCL locks ADCL/ADCH until ADCH is read; a completion while locked discards the result but still sets ADIF.
REQ-021 ADIF cleared by writing 1 to bit4 or by int_ack_i; set and clear in the same cycle -> set wins.
REQ-022 int_o = ADIF & ADIE, registered-free (combinational from flops).
REQ-023 ADSC write 0 SHALL have no effect; ADSC write 1 while FIRST/CONV ignored; ADSC reads 1 while FIRST/CONV.
REQ-024 ADEN written 0 mid-conversion: FSM -> IDLE next clock, no capture, no ADIF, ADSC=0; the next enable uses FIRST.
REQ-025 bus_o combinational: zero unless rd_i and an address matches; ADCSRB bits [7:3] read 0.

Reset
REQ-026 rst_i SHALL asynchronously set: ADCSRA=0, ADCSRB=0, ADMUX=0, ADCL=0, ADCH=0, lock=0, prescaler=0, FSM=IDLE, first-flag=1.
REQ-027 During reset: bus_o=0, int_o=0, sample_stb_o=0.

Structure
REQ-028 Register bit positions, FSM state encodings and default tick counts SHALL be in a shared include/package (atmega_adc_pkg).
REQ-029 The prescaler SHALL be a sub-module atmega_adc_prescaler (en, adps -> tick).

Verification
REQ-030 Test 1: ADPS=0, write ADCSRA=8'hC0, sample_i=10'h2A5 -> sample_stb_o 50 clocks later; ADCL=8'hA5, ADCH=8'h02, ADIF=1, ADSC reads 0.
REQ-031 Test 2: after Test 1, ADMUX=8'h20, ADSC=1, sample_i=10'h2A5 -> completion after 26 clocks; ADCH=8'hA9, ADCL=8'h40.
REQ-032 Test 3: ADIE=1, completion -> int_o=1; int_ack_i pulse in the same cycle as a second completion -> ADIF stays 1.
REQ-033 Test 4: read ADCL, then a completion with a new sample, then read ADCH -> old ADCH returned; the next completion updates both registers.
REQ-034 Test 5: ADCSRA=8'hE0, ADCSRB=0 -> sample_stb_o every 27 clocks after the first; write ADEN=0 mid-conversion -> no further strobe and ADIF unchanged.
REQ-035 Test 6: assert rst_i mid-conversion (async, off-edge) -> all registers 0 immediately; no strobe after release.
